// File: rtl/fifo_drain_pkg.sv
// Shared state type and frame-size helper for the FIFO drain serializer.
// Define FIFO_DRAIN_PARITY_EN to add an even-parity bit to every frame.
package fifo_drain_pkg;

`ifdef FIFO_DRAIN_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
`ifdef FIFO_DRAIN_PARITY_EN
    StParity,
`endif
    StStop
  } drain_state_t;

  // Serial bit slots per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned width, input bit parity);
    return width + 32'd2 + (parity ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/fifo_drain_serializer_bit_timer.sv
// Divides the clock by CLKS_PER_BIT; tick marks the last cycle of each serial bit.
// tick_nxt predicts next cycle's tick so callers can register last-cycle pulses.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] Last    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] PreLast = CntW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [CntW-1:0] cnt_q;

  assign tick     = !clr && (cnt_q == Last);
  // Valid while clr stays low; a wrap only re-ticks at once when a bit is one cycle long.
  assign tick_nxt = (CLKS_PER_BIT == 1) || (!clr && (cnt_q == PreLast));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == Last)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_drain_serializer.sv
// Read-side FIFO controller: pops one word at a time and sends it as a UART-style frame.
// Define FIFO_DRAIN_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATO_WIDTH   = 3,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BitCntW = $clog2(DATO_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATO_WIDTH - 1);

  drain_state_t          state_q;
  logic [DATO_WIDTH-1:0] shreg_q;
  logic [DATO_WIDTH-1:0] shreg_shift;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic                  fifo_rd_q;
  logic                  tx_out_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  timer_clr;
  logic                  tick;
  logic                  tick_nxt;
`ifdef FIFO_DRAIN_PARITY_EN
  logic                  parity_q;
`endif

  assign shreg_shift = shreg_q >> 1;
  assign timer_clr   = (state_q == StIdle) || (state_q == StPop) || (state_q == StLoad);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  // Outputs are registered, so each branch sets the value for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      fifo_rd_q    <= 1'b0;
      tx_out_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FIFO_DRAIN_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      fifo_rd_q    <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_en && !fifo_empty) begin
            state_q   <= StPop;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StLoad;
        end
        StLoad: begin
          shreg_q   <= fifo_data;
          bit_cnt_q <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
          parity_q  <= ^fifo_data;
`endif
          tx_out_q  <= 1'b0;
          state_q   <= StStart;
        end
        StStart: begin
          if (tick) begin
            state_q  <= StData;
            tx_out_q <= shreg_q[0];
          end
        end
        StData: begin
          if (tick) begin
            shreg_q   <= shreg_shift;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
`ifdef FIFO_DRAIN_PARITY_EN
              state_q  <= StParity;
              tx_out_q <= parity_q;
`else
              state_q      <= StStop;
              tx_out_q     <= 1'b1;
              frame_done_q <= tick_nxt;
`endif
            end else begin
              tx_out_q <= shreg_shift[0];
            end
          end
        end
`ifdef FIFO_DRAIN_PARITY_EN
        StParity: begin
          if (tick) begin
            state_q      <= StStop;
            tx_out_q     <= 1'b1;
            frame_done_q <= tick_nxt;
          end
        end
`endif
        StStop: begin
          if (tick) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            frame_done_q <= tick_nxt;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fifo_rd    = fifo_rd_q;
  assign tx_out     = tx_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench for fifo_drain_serializer with a behavioural FIFO and a frame scoreboard.
module tb_fifo_drain_serializer;
  import fifo_drain_pkg::*;

  localparam int unsigned DW         = 3;
  localparam int unsigned CPB        = 4;
  localparam int unsigned FrameSlots = frame_bits(DW, ParityEn);
  localparam int unsigned FrameCyc   = FrameSlots * CPB;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          tx_en      = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd;
  logic          tx_out;
  logic          busy;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int rd_consec = 0;
  int aborts = 0;
  logic rd_prev = 1'b0;

  logic [DW-1:0] fifo_mem[$];
  logic [DW:0]   exp_q[$];  // {hand-computed parity, word}

  fifo_drain_serializer #(
    .DATO_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // FIFO model: datout advances on the rising edge of the read strobe.
  always @(posedge fifo_rd) begin
    if (fifo_mem.size() > 0) fifo_data = fifo_mem.pop_front();
    fifo_empty = (fifo_mem.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_rd) rd_cnt++;
    if (fifo_rd && rd_prev) rd_consec++;
    rd_prev = fifo_rd;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input logic par);
    fifo_mem.push_back(w);
    exp_q.push_back({par, w});
    fifo_empty = 1'b0;
  endtask

  // sel: 0 fifo_rd==1, 1 tx_out==0, 2 frame_done==1, 3 busy==0
  task automatic wait_for(input string name, input int sel, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = (fifo_rd == 1'b1);
        1: hit = (tx_out == 1'b0);
        2: hit = (frame_done == 1'b1);
        default: hit = (busy == 1'b0);
      endcase
      if (hit) begin
        at = cyc;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  // Called at the first start-bit cycle; records the whole frame then scores it.
  task automatic capture_frame();
    logic        tx_s[FrameCyc];
    logic [DW:0] exp;
    logic [31:0] exp_slots;
    logic [31:0] rx_slots;
    int          glitches;
    int          fd_at;
    int          fd_n;
    bit          lost;
    glitches = 0;
    fd_at    = 0;
    fd_n     = 0;
    lost     = 1'b0;
    for (int k = 1; k <= FrameCyc; k++) begin
      if (k > 1) @(negedge clk);
      if (!rst) begin
        lost = 1'b1;
        break;
      end
      tx_s[k-1] = tx_out;
      if (frame_done) begin
        fd_n++;
        if (fd_at == 0) fd_at = k;
      end
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got a frame, required none");
      return;
    end
    exp = exp_q.pop_front();
    if (lost) begin
      aborts++;
      return;
    end
    exp_slots    = '0;
    exp_slots[0] = 1'b0;
    for (int i = 0; i < DW; i++) exp_slots[1+i] = exp[i];
    if (ParityEn) exp_slots[DW+1] = exp[DW];
    exp_slots[FrameSlots-1] = 1'b1;
    rx_slots = '0;
    for (int s = 0; s < FrameSlots; s++) rx_slots[s] = tx_s[s*CPB + CPB/2];
    for (int k = 0; k < FrameCyc; k++) if (tx_s[k] != exp_slots[k/CPB]) glitches++;
    check($sformatf("frame_slots word=%b", exp[DW-1:0]), rx_slots, exp_slots);
    check("frame_bit_stable", glitches, 0);
    check("frame_done_pos", fd_at, FrameCyc);
    check("frame_done_count", fd_n, 1);
  endtask

  initial begin : monitor
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && busy && prev_tx && !tx_out) capture_frame();
      prev_tx = tx_out;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t_pop, t_start, t_done, t_x, base;
    int rd_seen, low_seen, busy_seen;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_fifo_rd", fifo_rd, 0);
    check("reset_tx_out", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);

    // Empty FIFO with transmission enabled: nothing may happen.
    rst   = 1'b1;
    tx_en = 1'b1;
    rd_seen = 0; low_seen = 0; busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd) rd_seen++;
      if (!tx_out) low_seen++;
      if (busy) busy_seen++;
    end
    check("empty_no_rd", rd_seen, 0);
    check("empty_tx_high", low_seen, 0);
    check("empty_not_busy", busy_seen, 0);

    // Single word 101: pulse width, latency and frame length.
    push_word(3'b101, 1'b0);
    wait_for("pop_101", 0, 10, t_pop);
    @(negedge clk);
    check("rd_pulse_width", fifo_rd, 0);
    wait_for("start_101", 1, 10, t_start);
    check("pop_to_start", t_start - t_pop, 2);
    wait_for("done_101", 2, 60, t_done);
    check("frame_length", t_done - t_start + 1, FrameCyc);
    wait_for("idle_101", 3, 10, t_x);

    // Odd-parity word.
    push_word(3'b100, 1'b1);
    wait_for("done_100", 2, 60, t_done);
    wait_for("idle_100", 3, 10, t_x);

    // Three queued words back to back.
    tx_en = 1'b0;
    push_word(3'b001, 1'b1);
    push_word(3'b110, 1'b0);
    push_word(3'b011, 1'b0);
    base  = rd_cnt;
    tx_en = 1'b1;
    wait_for("done_b1", 2, 60, t_done);
    wait_for("start_b2", 1, 10, t_start);
    check("gap_1_2", t_start - t_done, 4);
    wait_for("done_b2", 2, 60, t_done);
    wait_for("start_b3", 1, 10, t_start);
    check("gap_2_3", t_start - t_done, 4);
    wait_for("done_b3", 2, 60, t_done);
    wait_for("idle_b3", 3, 10, t_x);
    repeat (5) @(negedge clk);
    check("burst_rd_count", rd_cnt - base, 3);

    // tx_en dropped during DATA of the first of two words.
    tx_en = 1'b0;
    push_word(3'b010, 1'b1);
    push_word(3'b111, 1'b1);
    base  = rd_cnt;
    tx_en = 1'b1;
    wait_for("start_e1", 1, 10, t_start);
    repeat (CPB + 1) @(negedge clk);
    tx_en = 1'b0;
    wait_for("done_e1", 2, 60, t_done);
    repeat (30) @(negedge clk);
    check("en_drop_rd_count", rd_cnt - base, 1);
    check("en_drop_idle", busy, 0);
    tx_en = 1'b1;
    @(negedge clk);
    check("reenable_pop", fifo_rd, 1);
    wait_for("done_e2", 2, 60, t_done);
    wait_for("idle_e2", 3, 10, t_x);

    // Reset during the second data bit: first word lost, second sent normally.
    tx_en = 1'b0;
    push_word(3'b001, 1'b1);
    push_word(3'b011, 1'b0);
    tx_en = 1'b1;
    wait_for("start_r1", 1, 10, t_start);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tx_out", tx_out, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_fifo_rd", fifo_rd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_for("done_r2", 2, 60, t_done);
    wait_for("idle_r2", 3, 10, t_x);
    repeat (5) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    check("rd_never_consecutive", rd_consec, 0);
    check("aborted_frames", aborts, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Downstream consumer of the project FIFO.
- Whenever the FIFO reports data and transmission is enabled, it issues a one-cycle read strobe and captures the popped word.
- It then emits the word on a single wire as an asynchronous-style serial frame: start bit, data LSB first, optional parity, stop bit.
- It is the read-side controller: its `fifo_rd` output drives the FIFO read strobe (`rclk`), and it watches the FIFO `empy` flag.

## Interface
- `DATO_WIDTH`, default 3: word width; must match the FIFO's `DATO_WIDTH`.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; minimum 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tx_en` in 1: permission to start a new frame. Sampled only in IDLE.
- `fifo_empty` in 1: FIFO `empy` flag; 1 means no data.
- `fifo_data` in DATO_WIDTH: FIFO `datout`.
- `fifo_rd` out 1: one-cycle read strobe to FIFO `rclk`.
- `tx_out` out 1: serial line; idle level 1.
- `busy` out 1: high from the POP cycle through the last STOP cycle.
- `frame_done` out 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
States: IDLE, POP, LOAD, START, DATA, PARITY (only with the macro), STOP.
- **IDLE**: `tx_out`=1. If `tx_en`=1 and `fifo_empty`=0, go to POP; otherwise stay.
- **POP**: `fifo_rd`=1 for exactly this cycle, then go to LOAD.
- **LOAD**: register `fifo_data` into the shift register and clear the bit timer, then go to START.
- **START**: `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**: `tx_out`=shreg[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATO_WIDTH bits, go to PARITY or STOP.
- **PARITY**: `tx_out`=even parity (XOR of the captured word) for CLKS_PER_BIT cycles.
- **STOP**: `tx_out`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the final cycle, then go to IDLE.

Counter widths and arithmetic:
- Bit timer: $clog2(CLKS_PER_BIT) bits, minimum 1. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Bit counter: $clog2(DATO_WIDTH+1) bits.
- No arithmetic overflow is permitted.

Boundary conditions:
- `fifo_empty` or `tx_en` changing mid-frame is ignored. A frame, once popped, always completes.
- `fifo_empty`=1 in IDLE: no strobe is issued, ever. There is no speculative pop.
- `tx_en` dropping during a frame: the current frame finishes, and no further POP occurs.
- Reset asserted mid-frame: immediately (asynchronously) IDLE, `tx_out`=1, `fifo_rd`=0. The partially sent word is lost. The FIFO has already advanced its read pointer.

## Timing
- Reset values: `fifo_rd`=0, `tx_out`=1, `busy`=0, `frame_done`=0, state IDLE, shift register 0, both counters 0.
- All outputs are registered.
- Latency:
  - POP is one cycle after the IDLE condition is met.
  - The start bit begins two cycles after POP (POP, LOAD, START).
- Frame length: (DATO_WIDTH+2)×CLKS_PER_BIT cycles, plus CLKS_PER_BIT cycles with parity.
- Back-to-back frames: at least 3 cycles of `tx_out`=1 (IDLE, POP, LOAD) between the end of the stop bit and the next start bit.
- FIFO contract:
  - `fifo_data` must be valid by the clock edge ending POP. The FIFO updates `datout` on the rising edge of its read strobe.
  - `fifo_rd` is never asserted on consecutive cycles.

## Configuration
- Macro `FIFO_DRAIN_PARITY_EN` defined:
  - The PARITY state exists.
  - Frames carry one even-parity bit between the last data bit and STOP.
- Macro undefined:
  - No parity logic is compiled in.
  - DATA goes directly to STOP.

## Structure
- Shared package `fifo_drain_pkg`:
  - State enum type `drain_state_t`.
  - Localparam function `frame_bits(width, parity)`, which returns width+2 plus the parity bit when enabled.
- One natural sub-module: `bit_timer`.
  - CLKS_PER_BIT divider with `clr` input and `tick` output.
  - `tick`=1 in the last cycle of each bit.
  - Reused for START, DATA, PARITY and STOP.

## Test plan
Bench configuration: DATO_WIDTH=3, CLKS_PER_BIT=4 unless stated.
1. Reset released, `fifo_empty`=1, `tx_en`=1 for 100 cycles -> `fifo_rd` never 1, `tx_out` constant 1, `busy`=0.
2. Word 3'b101, no parity -> `fifo_rd` pulse 1 cycle; two cycles later `tx_out` = 0,1,0,1,1, each bit 4 cycles; `frame_done` in cycle 20 of the frame.
3. With `FIFO_DRAIN_PARITY_EN` defined, word 3'b101 -> parity bit 0. Word 3'b100 -> parity bit 1. Frame length 24 cycles.
4. Three words queued (3'b001, 3'b110, 3'b011) -> three frames in order, exactly 3 idle-high cycles between them, three `fifo_rd` pulses total.
5. `tx_en` deasserted during DATA of the first of two queued words -> first frame completes, no second `fifo_rd`. Reasserting `tx_en` -> POP on the next cycle.
6. `rst` pulled low in the second DATA bit -> `tx_out`=1, `busy`=0 and `fifo_rd`=0 immediately, before any clock edge. After release, the next queued word is sent normally.
